// File: rtl/gsd_stream_accumulator_if.sv
// Stream port bundle for gsd_stream_accumulator: operand beats in, frame sum out.
// GSD_ACC_CNT_EN adds the out_count field carrying the beat count of each frame.
interface gsd_stream_accumulator_if #(
    parameter int LEN  = 16,
    parameter int IN_W = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [LEN-1:0]         out_data;
`ifdef GSD_ACC_CNT_EN
    logic [15:0]            out_count;
`endif

    modport master (
        output in_valid, in_data, in_last, out_ready,
`ifdef GSD_ACC_CNT_EN
        input  out_count,
`endif
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
`ifdef GSD_ACC_CNT_EN
        output out_count,
`endif
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/gsd_stream_accumulator.sv
// Carry-free signed-digit stream accumulator with chunked end-of-frame conversion
// to two's complement. GSD_ACC_CNT_EN enables the saturating per-frame beat counter.
module gsd_stream_accumulator #(
    parameter int LEN         = 16,
    parameter int IN_W        = 8,
    parameter int CONV_DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    gsd_stream_accumulator_if.slave  bus
);
    localparam int K    = (LEN + CONV_DIGITS - 1) / CONV_DIGITS;
    localparam int PADW = K * CONV_DIGITS;
    localparam int CW   = $clog2(K + 1);

    typedef enum logic [1:0] {ACC, CONV, DONE} state_t;
    state_t state;

    // Digit i of the accumulator is {acc_n[i], acc_p[i]}.
    logic [LEN-1:0]  acc_p, acc_n;
    logic [LEN-1:0]  op_p, op_n;
    logic [LEN-1:0]  sum_p, sum_n;
    logic [LEN-1:0]  mag;
    logic signed [LEN-1:0] in_ext;

    logic signed [2:0] psum [LEN];
    logic signed [2:0] tr   [LEN+1];
    logic signed [2:0] wd   [LEN];
    logic [LEN-1:0]    lownn;
    logic signed [2:0] s;

    logic [PADW-1:0]      p_pad, n_pad, res_pad;
    logic [CONV_DIGITS:0] cdiff;
    logic                 borrow;
    logic [CW-1:0]        cidx;
    int                   cbase;
    logic                 accept;

    function automatic logic signed [2:0] dval(input logic p, input logic n);
        return (p & ~n) ? 3'sd1 : ((n & ~p) ? -3'sd1 : 3'sd0);
    endfunction

`ifdef GSD_ACC_CNT_EN
    logic [15:0] cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    assign accept = bus.in_valid & bus.in_ready;
    assign in_ext = LEN'(bus.in_data);
    assign mag    = in_ext[LEN-1] ? LEN'(-in_ext) : LEN'(in_ext);
    assign op_p   = in_ext[LEN-1] ? '0 : mag;
    assign op_n   = in_ext[LEN-1] ? mag : '0;

    // Each digit's transfer depends only on its own sum and the sign of the
    // sum one position lower, so the add never ripples.
    always_comb begin
        s        = '0;
        sum_p    = '0;
        sum_n    = '0;
        lownn    = '0;
        lownn[0] = 1'b1;
        for (int i = 0; i <= LEN; i++) tr[i] = '0;
        for (int i = 0; i < LEN; i++) begin
            psum[i] = dval(acc_p[i], acc_n[i]) + dval(op_p[i], op_n[i]);
            wd[i]   = '0;
        end
        for (int i = 1; i < LEN; i++) lownn[i] = ~psum[i-1][2];
        for (int i = 0; i < LEN; i++) begin
            case (psum[i])
                3'sd2:  begin tr[i+1] = 3'sd1;  wd[i] = 3'sd0; end
                -3'sd2: begin tr[i+1] = -3'sd1; wd[i] = 3'sd0; end
                3'sd1:  begin
                    tr[i+1] = lownn[i] ? 3'sd1  : 3'sd0;
                    wd[i]   = lownn[i] ? -3'sd1 : 3'sd1;
                end
                -3'sd1: begin
                    tr[i+1] = lownn[i] ? 3'sd0  : -3'sd1;
                    wd[i]   = lownn[i] ? -3'sd1 : 3'sd1;
                end
                default: begin tr[i+1] = 3'sd0; wd[i] = 3'sd0; end
            endcase
        end
        for (int i = 0; i < LEN; i++) begin
            s        = wd[i] + tr[i];
            sum_p[i] = (s == 3'sd1);
            sum_n[i] = (s == -3'sd1);
        end
    end

    assign p_pad = PADW'(acc_p);
    assign n_pad = PADW'(acc_n);
    assign cbase = (cidx < CW'(K)) ? int'(cidx) * CONV_DIGITS : 0;

    always_comb begin
        cdiff = {1'b0, p_pad[cbase +: CONV_DIGITS]}
              - {1'b0, n_pad[cbase +: CONV_DIGITS]}
              - {{CONV_DIGITS{1'b0}}, borrow};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ACC;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            acc_p         <= '0;
            acc_n         <= '0;
            res_pad       <= '0;
            borrow        <= 1'b0;
            cidx          <= '0;
`ifdef GSD_ACC_CNT_EN
            cnt           <= '0;
            bus.out_count <= '0;
`endif
        end else begin
            case (state)
                ACC: begin
                    bus.in_ready <= ~(accept & bus.in_last);
                    if (accept) begin
                        acc_p <= sum_p;
                        acc_n <= sum_n;
`ifdef GSD_ACC_CNT_EN
                        cnt   <= sat_inc(cnt);
`endif
                        if (bus.in_last) begin
                            state  <= CONV;
                            cidx   <= '0;
                            borrow <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    if (cidx == CW'(K)) begin
                        bus.out_data  <= res_pad[LEN-1:0];
                        bus.out_valid <= 1'b1;
`ifdef GSD_ACC_CNT_EN
                        bus.out_count <= cnt;
`endif
                        state         <= DONE;
                    end else begin
                        res_pad[cbase +: CONV_DIGITS] <= cdiff[CONV_DIGITS-1:0];
                        borrow <= cdiff[CONV_DIGITS];
                        cidx   <= cidx + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        acc_p         <= '0;
                        acc_n         <= '0;
`ifdef GSD_ACC_CNT_EN
                        cnt           <= '0;
`endif
                        state         <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: doc/gsd_stream_accumulator.md
# gsd_stream_accumulator

Streaming signed accumulator that keeps its running sum in generalised signed-digit (GSD) form so every beat is added carry-free in one cycle, independent of width. At end of frame it converts the sum back to two's complement through a multi-cycle chunked borrow chain and presents it on a valid/ready output. It sits after the binary-to-GSD front end and the carry-free adder chain as the sequential, parametrised accumulate-and-convert stage.

## Interface
- `LEN`, 16, accumulator and result width in digits/bits; `LEN >= IN_W`.
- `IN_W`, 8, input operand width (two's complement).
- `CONV_DIGITS`, 4, digits converted per cycle; `1 <= CONV_DIGITS <= LEN`.
- `clk  input  1  clock`
- `rst  input  1  asynchronous, active-high reset`
- `in_valid  input  1  operand beat valid`
- `in_ready  output  1  block accepts a beat`
- `in_data  input  IN_W  signed operand`
- `in_last  input  1  final beat of frame`
- `out_valid  output  1  result valid`
- `out_ready  input  1  consumer accepts result`
- `out_data  output  LEN  two's-complement frame sum mod 2^LEN`
- `out_count  output  16  beats in frame (only with GSD_ACC_CNT_EN)`

## Operation
- Digit encoding: `2'b00`=0, `2'b01`=+1, `2'b10`=-1; `2'b11` never produced, treated as 0 if present.
- FSM states: ACC, CONV, DONE. Reset → ACC.
- ACC: `in_ready`=1. Accepted beat (`in_valid & in_ready`) is sign-extended to LEN, converted to GSD (magnitude bits, digit sign = operand sign), and added carry-free into the LEN-digit accumulator register. The carry out of digit LEN-1 is discarded (mod 2^LEN). `in_last` on an accepted beat → CONV.
- CONV: `in_ready`=0. K = ceil(LEN/CONV_DIGITS) cycles. Chunk j (digits j·CONV_DIGITS upward, last chunk truncated) is resolved as P−N with a 1-bit borrow registered between chunks; initial borrow 0. Bits are written into the result register.
- DONE: `out_valid`=1, `out_data` stable until `out_ready`. On handshake: accumulator cleared to all-zero digits, state → ACC.
- `in_valid` while `in_ready`=0 is ignored; `out_ready` while `out_valid`=0 is ignored.
- A frame may be a single beat (`in_last` on first beat).

## Timing
- Reset values: `in_ready`=0 while `rst` is high, then 1 from the first cycle after deassertion; `out_valid`=0; `out_data`=0; `out_count`=0; accumulator all zero digits; borrow 0.
- Throughput in ACC: one beat per cycle, no bubbles.
- Last beat accepted at edge t: CONV occupies cycles t+1..t+K; `out_valid` rises at edge t+K+1.
- Output handshake at edge u: `out_valid` falls and `in_ready` rises after edge u. There is no same-cycle bypass of a new beat.
- `rst` asserted in any state: immediate return to reset values. The partial frame is lost and no output is produced.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `GSD_ACC_CNT_EN` defined: `out_count` port present. The counter increments on each accepted beat and saturates at 0xFFFF. It is captured with the result, held through DONE, and restarts from 0 for the next frame.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset: assert `rst` mid-stream → `out_valid`=0, `out_data`=0; after release `in_ready`=1 the next cycle.
- LEN=16, IN_W=8, CONV_DIGITS=4; beats 5, −3, 100(last) at consecutive cycles → `out_data`=0x0066, `out_valid` exactly 5 cycles after the last handshake.
- Negatives: −128, −128, −1(last) → `out_data`=0xFEFF; with `GSD_ACC_CNT_EN`, `out_count`=3.
- Wrap: LEN=IN_W=8, CONV_DIGITS=3; beats 127, 127(last) → `out_data`=0xFE after K=3 conversion cycles.
- Backpressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 → `out_data` stable, `in_ready`=0, no beats absorbed; then `out_ready`=1 → a new frame of 7(last) yields 0x0007.
- Reset during CONV: the frame is discarded, and a following frame of 1(last) → `out_data`=0x0001.
